// File: rtl/batch_buffer_ctrl.sv
// Batch capture/drain controller: fills a dual-port memory with one batch of
// bytes from a source, then replays it to a transmitter one byte at a time.
module batch_buffer_ctrl #(
  parameter int BATCH_SIZE     = 1000,
  parameter int MEM_ADDR_WIDTH = $clog2(BATCH_SIZE),
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  output logic                      mem_wea,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0]     mem_dina,
  output logic                      mem_enb,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addrb,
  input  logic [DATA_WIDTH-1:0]     mem_doutb,
  output logic                      tx_valid,
  output logic [DATA_WIDTH-1:0]     tx_data,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    READ,
    LOAD,
    SEND
  } state_e;

  localparam logic [MEM_ADDR_WIDTH-1:0] LastAddr = MEM_ADDR_WIDTH'(BATCH_SIZE - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] AddrOne  = MEM_ADDR_WIDTH'(1);

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [MEM_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
  logic                      done_q, done_d;
  logic                      wr_accept;
  logic                      tx_accept;

  // abort masks the handshakes in the same cycle so nothing is counted
  assign in_ready  = (state_q == FILL) && !abort;
  assign tx_valid  = (state_q == SEND) && !abort;
  assign wr_accept = in_valid && in_ready;
  assign tx_accept = tx_valid && tx_ready;

  assign mem_wea   = wr_accept;
  assign mem_addra = wr_ptr_q;
  assign mem_dina  = in_data;
  assign mem_enb   = (state_q == READ);
  assign mem_addrb = rd_ptr_q;
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d  = FILL;
            wr_ptr_d = '0;
          end
        end
        FILL: begin
          // the final write holds wr_ptr at the last address instead of wrapping
          if (wr_accept) begin
            if (wr_ptr_q == LastAddr) begin
              state_d  = READ;
              rd_ptr_d = '0;
            end else begin
              wr_ptr_d = wr_ptr_q + AddrOne;
            end
          end
        end
        READ: begin
          state_d = LOAD;
        end
        LOAD: begin
          tx_data_d = mem_doutb;
          state_d   = SEND;
        end
        SEND: begin
          if (tx_accept) begin
            if (rd_ptr_q == LastAddr) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + AddrOne;
              state_d  = READ;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_batch_buffer_ctrl.sv
// Directed bench for batch_buffer_ctrl with BATCH_SIZE=4 and a behavioural
// dual-port memory whose port-B read is registered.
module tb_batch_buffer_ctrl;

  localparam int BatchSize = 4;
  localparam int AddrW     = 2;
  localparam int DataW     = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic             in_valid;
  logic [DataW-1:0] in_data;
  logic             in_ready;
  logic             mem_wea;
  logic [AddrW-1:0] mem_addra;
  logic [DataW-1:0] mem_dina;
  logic             mem_enb;
  logic [AddrW-1:0] mem_addrb;
  logic [DataW-1:0] mem_doutb;
  logic             tx_valid;
  logic [DataW-1:0] tx_data;
  logic             tx_ready;
  logic             busy;
  logic             done;

  logic [DataW-1:0] mem [BatchSize];

  int errors = 0;
  int checks = 0;

  batch_buffer_ctrl #(
    .BATCH_SIZE    (BatchSize),
    .MEM_ADDR_WIDTH(AddrW),
    .DATA_WIDTH    (DataW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_wea  (mem_wea),
    .mem_addra(mem_addra),
    .mem_dina (mem_dina),
    .mem_enb  (mem_enb),
    .mem_addrb(mem_addrb),
    .mem_doutb(mem_doutb),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: synchronous write on A, registered read on B
  always @(posedge clk) begin
    if (mem_wea) mem[mem_addra] <= mem_dina;
    if (mem_enb) mem_doutb <= mem[mem_addrb];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic v,
                               input logic [DataW-1:0] d, input logic r);
    start    = s;
    abort    = a;
    in_valid = v;
    in_data  = d;
    tx_ready = r;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, ".mem_wea"},  32'(mem_wea),  32'd0);
    checkOutput({tag, ".mem_enb"},  32'(mem_enb),  32'd0);
    checkOutput({tag, ".tx_valid"}, 32'(tx_valid), 32'd0);
    checkOutput({tag, ".busy"},     32'(busy),     32'd0);
  endtask

  logic [DataW-1:0] seqA [4];
  logic [DataW-1:0] seqB [4];
  logic             gapV [7];

  initial begin
    int wrCount;
    seqA = '{8'h11, 8'h22, 8'h33, 8'h44};
    seqB = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    gapV = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    mem_doutb = '0;

    // Reset state
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset.done",    32'(done),    32'd0);
    checkOutput("reset.tx_data", 32'(tx_data), 32'h00);

    // Back-to-back fill then drain with tx_ready=1
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("b2b.idle_busy", 32'(busy), 32'd0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, seqA[i], 1'b1);
      checkOutput($sformatf("b2b.in_ready%0d", i), 32'(in_ready),  32'd1);
      checkOutput($sformatf("b2b.wea%0d", i),      32'(mem_wea),   32'd1);
      checkOutput($sformatf("b2b.addra%0d", i),    32'(mem_addra), 32'(i));
      checkOutput($sformatf("b2b.dina%0d", i),     32'(mem_dina),  32'(seqA[i]));
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("b2b.enb%0d", i),       32'(mem_enb),   32'd1);
      checkOutput($sformatf("b2b.addrb%0d", i),     32'(mem_addrb), 32'(i));
      checkOutput($sformatf("b2b.rd_inready%0d", i), 32'(in_ready), 32'd0);
      cycle();
      checkOutput($sformatf("b2b.load_txv%0d", i),  32'(tx_valid),  32'd0);
      checkOutput($sformatf("b2b.load_enb%0d", i),  32'(mem_enb),   32'd0);
      cycle();
      checkOutput($sformatf("b2b.txv%0d", i),       32'(tx_valid),  32'd1);
      checkOutput($sformatf("b2b.txd%0d", i),       32'(tx_data),   32'(seqA[i]));
      checkOutput($sformatf("b2b.send_done%0d", i), 32'(done),      32'd0);
      cycle();
    end
    checkOutput("b2b.done_pulse", 32'(done), 32'd1);
    checkOutput("b2b.end_busy",   32'(busy), 32'd0);
    cycle();
    checkOutput("b2b.done_clear", 32'(done), 32'd0);

    // Gapped in_valid: only asserted cycles write, addresses contiguous
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle();
    wrCount = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, gapV[i], gapV[i] ? seqB[wrCount] : 8'hFF, 1'b0);
      checkOutput($sformatf("gap.wea%0d", i),   32'(mem_wea),   32'(gapV[i]));
      checkOutput($sformatf("gap.addra%0d", i), 32'(mem_addra), 32'(wrCount));
      if (gapV[i]) wrCount++;
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("gap.read_enb", 32'(mem_enb),   32'd1);
    checkOutput("gap.read_adr", 32'(mem_addrb), 32'd0);
    cycle();
    cycle();

    // Stall in SEND for 5 cycles
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall.txv%0d", i),   32'(tx_valid),  32'd1);
      checkOutput($sformatf("stall.txd%0d", i),   32'(tx_data),   32'hA1);
      checkOutput($sformatf("stall.enb%0d", i),   32'(mem_enb),   32'd0);
      checkOutput($sformatf("stall.addrb%0d", i), 32'(mem_addrb), 32'd0);
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("stall.release_txd", 32'(tx_data), 32'hA1);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("stall.read1_enb", 32'(mem_enb),   32'd1);
    checkOutput("stall.read1_adr", 32'(mem_addrb), 32'd1);
    cycle();

    // start in LOAD/SEND is ignored, then reset during SEND of byte 2
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("ign.load_busy", 32'(busy), 32'd1);
    cycle();
    checkOutput("ign.send_txv", 32'(tx_valid), 32'd1);
    checkOutput("ign.send_txd", 32'(tx_data),  32'hB2);
    cycle();
    checkOutput("ign.still_txv", 32'(tx_valid), 32'd1);
    checkOutput("ign.still_adr", 32'(mem_addrb), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkIdleOutputs("rstsend");
    checkOutput("rstsend.done",    32'(done),      32'd0);
    checkOutput("rstsend.tx_data", 32'(tx_data),   32'h00);
    checkOutput("rstsend.addra",   32'(mem_addra), 32'd0);
    checkOutput("rstsend.addrb",   32'(mem_addrb), 32'd0);
    cycle();
    checkOutput("rstsend.no_done", 32'(done), 32'd0);

    // Abort after two bytes in FILL
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
    checkOutput("abort.addra1", 32'(mem_addra), 32'd1);
    cycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    checkOutput("abort.mask_ready", 32'(in_ready), 32'd0);
    checkOutput("abort.mask_wea",   32'(mem_wea),  32'd0);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.done", 32'(done), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h88, 1'b0);
    checkOutput("abort.restart_wea",   32'(mem_wea),   32'd1);
    checkOutput("abort.restart_addra", 32'(mem_addra), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cycle();

    // abort in SEND masks tx_valid: reach SEND of a fresh batch first
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, seqA[i], 1'b0);
      cycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cycle();
    cycle();
    checkOutput("abtx.txv_before", 32'(tx_valid), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("abtx.txv_masked", 32'(tx_valid), 32'd0);
    cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("abtx.busy", 32'(busy), 32'd0);
    checkOutput("abtx.done", 32'(done), 32'd0);
    checkOutput("abtx.addrb", 32'(mem_addrb), 32'd0);

    // abort and start together in IDLE: stays IDLE
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    cycle();
    checkOutput("both.busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
    checkOutput("both.in_ready", 32'(in_ready), 32'd0);
    checkOutput("both.wea",      32'(mem_wea),  32'd0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
